pipe_skid_stage: RTL

//  Parametrised elastic pipeline register for inter-stage latches (ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_skid_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Elastic inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB). It carries a
// control bundle and a data bundle with a valid/ready handshake. A two-entry
// skid buffer lets downstream back-pressure be absorbed without a
// combinational path from out_ready to in_ready.
//
// The stage also provides:
//   - flush-to-bubble,
//   - debug step gating,
//   - saturating stall/flush counters for the debug unit.
//
// All state changes on the falling edge of clk.
//
// Ports
//   clk        : clock, state updates on negedge
//   reset      : synchronous, active-high reset
//   dbg_reset  : debug-unit reset, same effect as reset, lower priority
//   dbg_enable : 1 = stage steps this edge, 0 = full freeze
//   flush      : squash contents and insert a bubble (only while dbg_enable=1)
//   in_valid   : upstream word is present
//   in_ready   : stage can accept a word this edge
//   in_ctrl    : upstream control bundle
//   in_data    : upstream data bundle
//   out_valid  : out_ctrl/out_data hold a real word
//   out_ready  : downstream consumes this edge
//   out_ctrl   : control bundle to next stage, zero whenever out_valid=0
//   out_data   : data bundle to next stage
//   occupancy  : words held (0, 1 or 2)
//   stall_cnt  : saturating count of stalled edges
//   flush_cnt  : saturating count of executed flushes
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int CTRL_W          = 16,
  parameter int DATA_W          = 96,
  parameter int CNT_W           = 16,
  parameter bit CLR_DATA_BUBBLE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dbg_reset,
  input  logic              dbg_enable,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // The encoding doubles as the occupancy value.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [DATA_W-1:0] skid_data_r;
  logic              accept_s;
  logic              fire_s;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Handshake qualifiers.
  // in_ready depends only on registered state and dbg_enable, which keeps the
  // path from out_ready to in_ready free of combinational logic.
  always_comb begin
    in_ready = dbg_enable & (state_r != ST_TWO);
    accept_s = in_valid & in_ready;
    fire_s   = out_valid & out_ready & dbg_enable;
  end

  assign occupancy = state_r;

  // Main/skid storage, state and counters.
  // Priority: reset > dbg_reset > flush > step > hold.
  always_ff @(negedge clk) begin
    if (reset || dbg_reset) begin
      state_r     <= ST_EMPTY;
      out_valid   <= 1'b0;
      out_ctrl    <= {CTRL_W{1'b0}};
      out_data    <= {DATA_W{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
      stall_cnt   <= {CNT_W{1'b0}};
      flush_cnt   <= {CNT_W{1'b0}};
    end else if (dbg_enable) begin
      if (flush) begin
        // A flush discards both stored words and any word offered this edge.
        state_r     <= ST_EMPTY;
        out_valid   <= 1'b0;
        out_ctrl    <= {CTRL_W{1'b0}};
        if (CLR_DATA_BUBBLE) begin
          out_data <= {DATA_W{1'b0}};
        end else begin
          out_data <= out_data;
        end
        skid_ctrl_r <= {CTRL_W{1'b0}};
        skid_data_r <= {DATA_W{1'b0}};
        flush_cnt   <= sat_inc(flush_cnt);
      end else begin
        if (out_valid && !out_ready) begin
          stall_cnt <= sat_inc(stall_cnt);
        end else begin
          stall_cnt <= stall_cnt;
        end
        case (state_r)
          ST_EMPTY: begin
            if (accept_s) begin
              out_valid <= 1'b1;
              out_ctrl  <= in_ctrl;
              out_data  <= in_data;
              state_r   <= ST_ONE;
            end else begin
              state_r   <= ST_EMPTY;
            end
          end
          ST_ONE: begin
            if (accept_s && fire_s) begin
              out_ctrl <= in_ctrl;
              out_data <= in_data;
              state_r  <= ST_ONE;
            end else if (accept_s) begin
              // Downstream is stalled, so park the new word in the skid register.
              skid_ctrl_r <= in_ctrl;
              skid_data_r <= in_data;
              state_r     <= ST_TWO;
            end else if (fire_s) begin
              // The stage drains to a bubble; control becomes a NOP.
              out_valid <= 1'b0;
              out_ctrl  <= {CTRL_W{1'b0}};
              if (CLR_DATA_BUBBLE) begin
                out_data <= {DATA_W{1'b0}};
              end else begin
                out_data <= out_data;
              end
              state_r <= ST_EMPTY;
            end else begin
              state_r <= ST_ONE;
            end
          end
          ST_TWO: begin
            if (fire_s) begin
              out_ctrl    <= skid_ctrl_r;
              out_data    <= skid_data_r;
              skid_ctrl_r <= {CTRL_W{1'b0}};
              skid_data_r <= {DATA_W{1'b0}};
              state_r     <= ST_ONE;
            end else begin
              state_r <= ST_TWO;
            end
          end
          default: begin
            state_r   <= ST_EMPTY;
            out_valid <= 1'b0;
            out_ctrl  <= {CTRL_W{1'b0}};
          end
        endcase
      end
    end else begin
      // While frozen, every register and counter holds its value.
      state_r <= state_r;
    end
  end

endmodule
